attack_resolver: RTL and testbench

Per-frame hit arbiter sitting directly downstream of the two `player_next_state_calc` instances and feeding their `opponent_attack_connected` / `player_attack_connected` inputs. Once per frame it waits for both player generators to settle, then computes the gap between the fighters. It decides whether a kick or grab connected, and latches the round result until reset. State encodings, `PLAYER_WIDTH`, `STATE_DEPTH`, `POSITION_DEPTH` and `SPRITE_INDEX_DEPTH` come from `params.vh`.

---
 rtl/attack_resolver.sv | 190 +++++++++++++++++++
 tb/tb_attack_resolver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_resolver.sv
// attack_resolver: per-frame hit arbiter between two player state generators.
// Waits for both generators to settle after a frame edge, evaluates kick/grab
// reach from the fighter gap, and latches the round result until reset.
// Optional build macro: ATTACK_RESOLVER_CLASH_COUNT_EN adds an 8-bit
// saturating clash counter output (clash_count).
// Player-state encodings and widths are parameters whose defaults match the
// shared game parameter set; override them at instantiation if that changes.
//
// state  | meaning
// IDLE   | waiting for a frame_clk rising edge
// WAIT   | frame started, waiting for both done_gen; a new frame edge restarts
// EVAL   | samples player inputs, registers hit1/hit2
// DECIDE | drives results and the frame_resolved / clash pulses
// OVER   | round decided, inputs ignored until reset
module attack_resolver #(
   parameter int PLAYER_WIDTH       = 32,
   parameter int STATE_DEPTH        = 3,
   parameter int POSITION_DEPTH     = 10,
   parameter int SPRITE_INDEX_DEPTH = 4,
   parameter logic [STATE_DEPTH-1:0] ST_KICK  = 3'd3,
   parameter logic [STATE_DEPTH-1:0] ST_BLOCK = 3'd4,
   parameter logic [STATE_DEPTH-1:0] ST_GRAB  = 3'd5,
   parameter logic [STATE_DEPTH-1:0] ST_WIN   = 3'd6,
   parameter logic [STATE_DEPTH-1:0] ST_LOSE  = 3'd7,
   parameter int KICK_ACTIVE_FIRST  = 2,
   parameter int KICK_ACTIVE_LAST   = 4,
   parameter int KICK_RANGE         = 24,
   parameter int GRAB_ACTIVE        = 3,
   parameter int GRAB_RANGE         = 8
) (
   input  logic                          sys_clk,
   input  logic                          reset,
   input  logic                          frame_clk,
   input  logic [STATE_DEPTH-1:0]        p1_state,
   input  logic [STATE_DEPTH-1:0]        p2_state,
   input  logic [SPRITE_INDEX_DEPTH-1:0] p1_index,
   input  logic [SPRITE_INDEX_DEPTH-1:0] p2_index,
   input  logic [POSITION_DEPTH-1:0]     p1_position,
   input  logic [POSITION_DEPTH-1:0]     p2_position,
   input  logic                          p1_done,
   input  logic                          p2_done,
   output logic                          p1_attack_connected,
   output logic                          p2_attack_connected,
   output logic                          round_over,
   output logic                          clash,
   output logic                          frame_resolved
`ifdef ATTACK_RESOLVER_CLASH_COUNT_EN
   ,
   output logic [7:0]                    clash_count
`endif
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WAIT   = 3'd1;
   localparam logic [2:0] EVAL   = 3'd2;
   localparam logic [2:0] DECIDE = 3'd3;
   localparam logic [2:0] OVER   = 3'd4;

   localparam logic [SPRITE_INDEX_DEPTH-1:0] KICK_FIRST_IDX = SPRITE_INDEX_DEPTH'(KICK_ACTIVE_FIRST);
   localparam logic [SPRITE_INDEX_DEPTH-1:0] KICK_LAST_IDX  = SPRITE_INDEX_DEPTH'(KICK_ACTIVE_LAST);
   localparam logic [SPRITE_INDEX_DEPTH-1:0] GRAB_IDX       = SPRITE_INDEX_DEPTH'(GRAB_ACTIVE);
   localparam logic [POSITION_DEPTH-1:0]     KICK_REACH     = POSITION_DEPTH'(KICK_RANGE);
   localparam logic [POSITION_DEPTH-1:0]     GRAB_REACH     = POSITION_DEPTH'(GRAB_RANGE);
   localparam logic [POSITION_DEPTH:0]       WIDTH_EXT      = (POSITION_DEPTH+1)'(PLAYER_WIDTH);

   logic [2:0] state_q, state_d;
   logic       frame_q;
   logic       frame_edge;
   logic       hit1_q, hit1_d;
   logic       hit2_q, hit2_d;
   logic       p1_conn_q, p1_conn_d;
   logic       p2_conn_q, p2_conn_d;
   logic       deciding;
   logic       p1_win;
   logic       p2_win;
   logic [POSITION_DEPTH:0]   gap_raw;
   logic [POSITION_DEPTH-1:0] gap;

   // A hit needs the attacker in an active frame of its move and the defender
   // still in play; only kicks can be blocked.
   function automatic logic hit_calc(
      input logic [STATE_DEPTH-1:0]        atk_state,
      input logic [SPRITE_INDEX_DEPTH-1:0] atk_index,
      input logic [STATE_DEPTH-1:0]        def_state,
      input logic [POSITION_DEPTH-1:0]     gap_px
   );
      logic kick_hit;
      logic grab_hit;
      logic def_live;
      def_live = (def_state != ST_WIN) && (def_state != ST_LOSE);
      kick_hit = (atk_state == ST_KICK) && (atk_index >= KICK_FIRST_IDX) &&
                 (atk_index <= KICK_LAST_IDX) && (gap_px <= KICK_REACH) &&
                 (def_state != ST_BLOCK);
      grab_hit = (atk_state == ST_GRAB) && (atk_index == GRAB_IDX) &&
                 (gap_px <= GRAB_REACH);
      return def_live && (kick_hit || grab_hit);
   endfunction

   // Gap between P1's right edge and P2's left edge; overlap clamps to zero.
   always_comb begin
      gap_raw = {1'b0, p2_position} - ({1'b0, p1_position} + WIDTH_EXT);
      gap     = gap_raw[POSITION_DEPTH] ? '0 : gap_raw[POSITION_DEPTH-1:0];
   end

   assign frame_edge = frame_clk & ~frame_q;
   assign deciding   = (state_q == DECIDE);
   assign p1_win     = deciding & hit1_q & ~hit2_q;
   assign p2_win     = deciding & hit2_q & ~hit1_q;

   // Results are visible during DECIDE so they appear two edges after done is
   // sampled; the sticky flops hold them from then on.
   assign p1_attack_connected = p1_conn_q | p1_win;
   assign p2_attack_connected = p2_conn_q | p2_win;
   assign round_over          = p1_attack_connected | p2_attack_connected;
   assign clash               = deciding & hit1_q & hit2_q;
   assign frame_resolved      = deciding;

   // Frame clock history for rising-edge detection.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) frame_q <= 1'b0;
      else        frame_q <= frame_clk;
   end

   // Next-state and result logic.
   always_comb begin
      state_d   = state_q;
      hit1_d    = hit1_q;
      hit2_d    = hit2_q;
      p1_conn_d = p1_conn_q;
      p2_conn_d = p2_conn_q;
      case (state_q)
         IDLE: begin
            if (frame_edge) state_d = WAIT;
         end
         WAIT: begin
            // A fresh frame edge wins over done: the stale frame is dropped.
            if (frame_edge)             state_d = WAIT;
            else if (p1_done & p2_done) state_d = EVAL;
         end
         EVAL: begin
            hit1_d  = hit_calc(p1_state, p1_index, p2_state, gap);
            hit2_d  = hit_calc(p2_state, p2_index, p1_state, gap);
            state_d = DECIDE;
         end
         DECIDE: begin
            p1_conn_d = p1_conn_q | p1_win;
            p2_conn_d = p2_conn_q | p2_win;
            state_d   = (p1_win | p2_win) ? OVER : IDLE;
         end
         OVER:    state_d = OVER;
         default: state_d = IDLE;
      endcase
   end

   // FSM and result registers.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         hit1_q    <= 1'b0;
         hit2_q    <= 1'b0;
         p1_conn_q <= 1'b0;
         p2_conn_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hit1_q    <= hit1_d;
         hit2_q    <= hit2_d;
         p1_conn_q <= p1_conn_d;
         p2_conn_q <= p2_conn_d;
      end
   end

`ifdef ATTACK_RESOLVER_CLASH_COUNT_EN
   logic [7:0] clash_count_q, clash_count_d;

   // Saturating count of clash pulses.
   always_comb begin
      clash_count_d = clash_count_q;
      if (clash && (clash_count_q != 8'hFF)) clash_count_d = clash_count_q + 8'd1;
   end

   // Clash counter register.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) clash_count_q <= 8'd0;
      else        clash_count_q <= clash_count_d;
   end

   assign clash_count = clash_count_q;
`endif

endmodule

// File: tb/tb_attack_resolver.sv
// Scoreboard bench for attack_resolver: directed frames from the test plan
// followed by randomized frames checked against a behavioural model.
module tb_attack_resolver;

   localparam int PW = 32;
   localparam logic [2:0] S_NOTHING = 3'd0, S_FWD = 3'd1, S_BACK = 3'd2, S_KICK = 3'd3,
                          S_BLOCK = 3'd4, S_GRAB = 3'd5, S_WIN = 3'd6, S_LOSE = 3'd7;

   logic       sys_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_clk = 1'b0;
   logic [2:0] p1_state = '0, p2_state = '0;
   logic [3:0] p1_index = '0, p2_index = '0;
   logic [9:0] p1_position = '0, p2_position = '0;
   logic       p1_done = 1'b0, p2_done = 1'b0;
   logic       p1c, p2c, round_over, clash, frame_resolved;
`ifdef ATTACK_RESOLVER_CLASH_COUNT_EN
   logic [7:0] clash_count;
`endif

   attack_resolver dut (
      .sys_clk(sys_clk), .reset(rst_n), .frame_clk(frame_clk),
      .p1_state(p1_state), .p2_state(p2_state),
      .p1_index(p1_index), .p2_index(p2_index),
      .p1_position(p1_position), .p2_position(p2_position),
      .p1_done(p1_done), .p2_done(p2_done),
      .p1_attack_connected(p1c), .p2_attack_connected(p2c),
      .round_over(round_over), .clash(clash), .frame_resolved(frame_resolved)
`ifdef ATTACK_RESOLVER_CLASH_COUNT_EN
      , .clash_count(clash_count)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit p1c;
      bit p2c;
      bit clash;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   bit   m_p1 = 0, m_p2 = 0;
   int   m_cc = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // Reach rules stated directly from the game rules.
   function automatic bit model_hit(input logic [2:0] as, input int ai,
                                    input logic [2:0] ds, input int gap);
      if (ds == S_WIN || ds == S_LOSE) return 0;
      if (as == S_KICK && ai >= 2 && ai <= 4 && gap <= 24 && ds != S_BLOCK) return 1;
      if (as == S_GRAB && ai == 3 && gap <= 8) return 1;
      return 0;
   endfunction

   // Monitor: every frame_resolved pulse consumes one expected outcome.
   always @(negedge sys_clk) begin
      exp_t e;
      if (rst_n) begin
         if (p1c && p2c) begin
            failures++;
            $display("FAIL both_connected actual=1 required=0 t=%0t", $time);
         end
         if (clash && !frame_resolved) begin
            failures++;
            $display("FAIL clash_outside_resolve actual=1 required=0 t=%0t", $time);
         end
         if (frame_resolved) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_resolve actual=1 required=0 t=%0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("mon_p1_connected", int'(p1c), int'(e.p1c));
               check("mon_p2_connected", int'(p2c), int'(e.p2c));
               check("mon_clash", int'(clash), int'(e.clash));
               check("mon_round_over", int'(round_over), int'(e.p1c | e.p2c));
            end
         end
      end
   end

   task automatic scramble();
      p1_state    = 3'($urandom_range(0, 7));
      p2_state    = 3'($urandom_range(0, 7));
      p1_index    = 4'($urandom_range(0, 15));
      p2_index    = 4'($urandom_range(0, 15));
      p1_position = 10'($urandom_range(0, 1023));
      p2_position = 10'($urandom_range(0, 1023));
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      rst_n = 1'b0;
      frame_clk = 1'b0;
      p1_done = 1'b0;
      p2_done = 1'b0;
      repeat (2) @(negedge sys_clk);
      check("rst_p1_connected", int'(p1c), 0);
      check("rst_p2_connected", int'(p2c), 0);
      check("rst_round_over", int'(round_over), 0);
      check("rst_frame_resolved", int'(frame_resolved), 0);
      rst_n = 1'b1;
      m_p1 = 0;
      m_p2 = 0;
      m_cc = 0;
      exp_q.delete();
      @(negedge sys_clk);
   endtask

   task automatic run_frame(input logic [2:0] s1, input int i1, input logic [2:0] s2,
                            input int i2, input int pos1, input int pos2,
                            input bit drop, input bit abort);
      int  g;
      bit  h1, h2, over, got;
      int  lat;
      @(negedge sys_clk);
      frame_clk = 1'b1;
      p1_done = 1'b0;
      p2_done = 1'b0;
      scramble();
      repeat (2) @(negedge sys_clk);
      frame_clk = 1'b0;
      if (drop) begin
         repeat (3) @(negedge sys_clk);
         frame_clk = 1'b1;
         scramble();
         repeat (2) @(negedge sys_clk);
         frame_clk = 1'b0;
      end
      repeat ($urandom_range(1, 3)) @(negedge sys_clk);
      g = pos2 - pos1 - PW;
      if (g < 0) g = 0;
      h1 = model_hit(s1, i1, s2, g);
      h2 = model_hit(s2, i2, s1, g);
      over = m_p1 | m_p2;
      if (!over && !abort)
         exp_q.push_back('{p1c: m_p1 | (h1 & !h2), p2c: m_p2 | (h2 & !h1), clash: h1 & h2});
      p1_state    = s1;
      p2_state    = s2;
      p1_index    = i1[3:0];
      p2_index    = i2[3:0];
      p1_position = pos1[9:0];
      p2_position = pos2[9:0];
      p1_done = 1'b1;
      p2_done = 1'b1;
      if (abort) begin
         @(negedge sys_clk);
         rst_n = 1'b0;
         #1;
         check("abort_p1_connected", int'(p1c), 0);
         check("abort_p2_connected", int'(p2c), 0);
         check("abort_round_over", int'(round_over), 0);
         check("abort_frame_resolved", int'(frame_resolved), 0);
         @(negedge sys_clk);
         rst_n = 1'b1;
         m_p1 = 0;
         m_p2 = 0;
         m_cc = 0;
         repeat (10) @(negedge sys_clk);
      end else if (!over) begin
         lat = 0;
         got = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            lat++;
            if (frame_resolved) begin
               got = 1;
               break;
            end
         end
         check("resolve_latency", got ? lat : -1, 2);
         if (h1 && !h2) m_p1 = 1;
         if (h2 && !h1) m_p2 = 1;
         if (h1 && h2) m_cc = (m_cc < 255) ? m_cc + 1 : 255;
      end else begin
         repeat (8) @(negedge sys_clk);
      end
      p1_done = 1'b0;
      p2_done = 1'b0;
      scramble();
      repeat (2) @(negedge sys_clk);
      check("level_p1_connected", int'(p1c), int'(m_p1));
      check("level_p2_connected", int'(p2c), int'(m_p2));
      check("level_round_over", int'(round_over), int'(m_p1 | m_p2));
`ifdef ATTACK_RESOLVER_CLASH_COUNT_EN
      check("clash_count", int'(clash_count), m_cc);
`endif
   endtask

   initial begin
      logic [2:0] pick [9];
      int p1x, off;
      pick = '{S_KICK, S_KICK, S_GRAB, S_GRAB, S_NOTHING, S_BLOCK, S_WIN, S_LOSE, S_FWD};

      do_reset();
      // gap 20 kick into block, kick past window, kick at gap 25, clash
      run_frame(S_KICK, 3, S_BLOCK, 0, 100, 152, 0, 0);
      run_frame(S_KICK, 5, S_NOTHING, 0, 100, 152, 0, 0);
      run_frame(S_KICK, 3, S_NOTHING, 0, 100, 157, 0, 0);
      run_frame(S_KICK, 2, S_KICK, 2, 100, 142, 0, 0);
      // dropped frame (done withheld past next edge), then a mid-EVAL reset
      run_frame(S_KICK, 3, S_BLOCK, 0, 100, 152, 1, 0);
      run_frame(S_KICK, 3, S_NOTHING, 0, 100, 152, 0, 1);
      // P1 kick lands and stays latched through five more frames
      run_frame(S_KICK, 3, S_NOTHING, 0, 100, 152, 0, 0);
      for (int f = 0; f < 5; f++) run_frame(S_NOTHING, 0, S_KICK, 3, 100, 140, 0, 0);
      do_reset();
      run_frame(S_KICK, 4, S_NOTHING, 0, 100, 156, 0, 0);
      do_reset();
      run_frame(S_GRAB, 3, S_BLOCK, 0, 100, 138, 0, 0);
      do_reset();
      run_frame(S_NOTHING, 0, S_GRAB, 3, 100, 127, 0, 0);
      do_reset();
`ifdef ATTACK_RESOLVER_CLASH_COUNT_EN
      for (int f = 0; f < 300; f++) run_frame(S_KICK, 2, S_KICK, 2, 100, 142, 0, 0);
      do_reset();
`endif
      for (int f = 0; f < 150; f++) begin
         p1x = $urandom_range(0, 400);
         off = $urandom_range(0, 60) - 15;
         run_frame(pick[$urandom_range(0, 8)], $urandom_range(0, 7),
                   pick[$urandom_range(0, 8)], $urandom_range(0, 7),
                   p1x, p1x + PW + off, 0, 0);
         if (m_p1 || m_p2) begin
            run_frame(S_KICK, 3, S_KICK, 3, 100, 140, 0, 0);
            do_reset();
         end
      end
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge sys_clk);
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_expectations actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
